mips_mc_ctrl: RTL

Multi-cycle MIPS control unit. It sequences the shared datapath (one memory port, one ALU, the selector muxes) over several clocks per instruction, and drives every mux select, register write enable and memory strobe. It sits beside the datapath and consumes the opcode field of the instruction register and the ALU zero flag. Memory accesses use a ready handshake, so variable-latency memory stalls the sequence.

---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/mips_mc_ctrl_if.sv | 38 +++
 rtl/mips_mc_ctrl_outdec.sv | 77 +++++++
 rtl/mips_mc_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its datapath.
// Optional feature macro: MIPS_MC_CTRL_JUMP_EN adds the JUMP state.
package mips_ctrl_pkg;

   // Opcode field values (instr[31:26]) recognised by the controller.
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU decoder request.
   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_op_t;

   // ALU B operand mux.
   typedef enum logic [1:0] {
      SRCB_REG     = 2'd0,
      SRCB_FOUR    = 2'd1,
      SRCB_IMM     = 2'd2,
      SRCB_IMM_SH2 = 2'd3
   } alu_src_b_t;

   // PC source mux.
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'd0,
      PCSRC_ALUOUT = 2'd1,
      PCSRC_JUMP   = 2'd2
   } pc_src_t;

   // Controller states; JUMP only exists when the jump feature is built in.
   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_ILLEGAL = 4'd12
`ifdef MIPS_MC_CTRL_JUMP_EN
      ,
      S_JUMP    = 4'd13
`endif
   } state_t;

   // Complete control word driven towards the datapath.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      alu_src_b_t alu_src_b;
      alu_op_t    alu_op;
      pc_src_t    pc_src;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and
// the datapath (slave).
interface mips_mc_ctrl_if;

   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_src;
   logic       illegal_op;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_src, illegal_op
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_src, illegal_op
   );

endinterface

// File: rtl/mips_mc_ctrl_outdec.sv
// State-to-control-word decode for the multi-cycle MIPS controller.
// Purely combinational; mem_ready only qualifies ir_write/pc_write in FETCH.
// Optional feature macro: MIPS_MC_CTRL_JUMP_EN decodes the JUMP state.
module mips_mc_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   // Decode the control word for the current state.
   always_comb begin
      // NOTE: every field gets a default before the case so no path can
      // leave a field unassigned, which would otherwise infer a latch.
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_src        = PCSRC_ALUOUT;
            ctrl.pc_write_cond = 1'b1;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
`ifdef MIPS_MC_CTRL_JUMP_EN
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PCSRC_JUMP;
         end
`endif
         S_ILLEGAL: begin
            ctrl.illegal_op = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing the shared datapath.
// Holds the state register and next-state logic; output decode lives in
// mips_mc_ctrl_outdec.
// Optional feature macro: MIPS_MC_CTRL_JUMP_EN enables the j instruction.
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   mips_mc_ctrl_if.master bus
);

   state_t state;
   state_t next_state;
   ctrl_t  ctrl;

   // State register; reset forces IDLE immediately, independent of clk.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state: memory states hold until mem_ready, DECODE dispatches.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   next_state = S_FETCH;
         S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = S_EXEC;
               OP_BEQ:       next_state = S_BRANCH;
               OP_ADDI:      next_state = S_ADDIEX;
`ifdef MIPS_MC_CTRL_JUMP_EN
               OP_J:         next_state = S_JUMP;
`endif
               default:      next_state = S_ILLEGAL;
            endcase
         end
         S_MEMADR: next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (bus.mem_ready) next_state = S_MEMWB;
         S_MEMWB:  next_state = S_FETCH;
         S_MEMWR:  if (bus.mem_ready) next_state = S_FETCH;
         S_EXEC:   next_state = S_ALUWB;
         S_ALUWB:  next_state = S_FETCH;
         S_BRANCH: next_state = S_FETCH;
         S_ADDIEX: next_state = S_ADDIWB;
         S_ADDIWB: next_state = S_FETCH;
`ifdef MIPS_MC_CTRL_JUMP_EN
         S_JUMP:   next_state = S_FETCH;
`endif
         S_ILLEGAL: next_state = S_FETCH;
         default:  next_state = S_IDLE;
      endcase
   end

   mips_mc_ctrl_outdec u_outdec (
      .state     (state),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.iord          = ctrl.iord;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_src        = ctrl.pc_src;
   assign bus.illegal_op    = ctrl.illegal_op;

endmodule
